// File: rtl/eu_issue_scheduler.sv
// Issue scheduler in front of eu_reg_alu: FIFO of decoded words, RAW/WAW hazard stall, retire pulse.
// Define EU_SCHED_PERF_CNT_EN to build the cycle/retire/stall counters; otherwise they read as zero.
module eu_issue_scheduler #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            in_instr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [31:0]            eu_instr,
  output logic                   eu_valid,
  output logic                   retire,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [15:0]            cycle_cnt,
  output logic [15:0]            retire_cnt,
  output logic [15:0]            stall_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       w;
  } sb_entry_t;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  sb_entry_t     sb_q [LATENCY];
  sb_entry_t     sb_d [LATENCY];
  logic [31:0]   eu_instr_q, eu_instr_d;
  logic          eu_valid_q;

  logic [31:0] head;
  logic        head_mov, head_w, not_empty, hazard, push, issue;
  logic [2:0]  head_dest;

  // Byte/word aliasing: only two word registers compare all three index bits.
  function automatic logic reg_match(input logic [2:0] a, input logic aw,
                                     input logic [2:0] b, input logic bw);
    if (aw && bw) return a == b;
    return a[1:0] == b[1:0];
  endfunction

  // in_valid/in_ready: a word transfers on a rising edge where both are high and flush is low;
  // in_ready depends on queue state only. eu_valid is a one-cycle pulse with no back-pressure.
  assign in_ready  = count_q < (AW+1)'(DEPTH);
  assign not_empty = count_q != '0;
  assign push      = in_valid && in_ready && !flush;
  assign issue     = not_empty && !hazard && !flush;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_mov  = head[31];
    head_w    = head_mov ? head[24] : head[8];
    head_dest = head_mov ? head[18:16] : (head[9] ? head[5:3] : head[2:0]);
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      if (sb_q[k].valid) begin
        if (head_mov) begin
          hazard = hazard | reg_match(sb_q[k].dest, sb_q[k].w, head_dest, head_w);
        end else begin
          hazard = hazard | reg_match(sb_q[k].dest, sb_q[k].w, head[5:3], head_w)
                          | reg_match(sb_q[k].dest, sb_q[k].w, head[2:0], head_w);
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    eu_instr_d = issue ? head : eu_instr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, issue})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Scoreboard shifts every cycle; flush leaves in-flight entries to retire normally.
  always_comb begin
    sb_d[0] = issue ? '{valid: 1'b1, dest: head_dest, w: head_w} : '0;
    for (int k = 1; k < LATENCY; k++) sb_d[k] = sb_q[k-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      eu_instr_q <= '0;
      eu_valid_q <= 1'b0;
      for (int k = 0; k < LATENCY; k++) sb_q[k] <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      eu_instr_q <= eu_instr_d;
      eu_valid_q <= issue;
      for (int k = 0; k < LATENCY; k++) sb_q[k] <= sb_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

  assign eu_instr = eu_instr_q;
  assign eu_valid = eu_valid_q;
  assign retire   = sb_q[LATENCY-1].valid;
  assign q_count  = count_q;

`ifdef EU_SCHED_PERF_CNT_EN
  logic        stall;
  logic [15:0] cycle_cnt_q, retire_cnt_q, stall_cnt_q;

  assign stall = not_empty && hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
      if (retire) retire_cnt_q <= retire_cnt_q + 16'd1;
      if (stall)  stall_cnt_q  <= stall_cnt_q + 16'd1;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  assign cycle_cnt  = 16'h0000;
  assign retire_cnt = 16'h0000;
  assign stall_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_eu_issue_scheduler.sv
// Bench for eu_issue_scheduler: issue order, hazard stall timing, queue full, flush, reset.
module tb_eu_issue_scheduler;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_instr = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        in_ready, eu_valid, retire;
  logic [31:0] eu_instr;
  logic [2:0]  q_count;
  logic [15:0] cycle_cnt, retire_cnt, stall_cnt;

  eu_issue_scheduler #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .eu_instr(eu_instr), .eu_valid(eu_valid),
    .retire(retire), .q_count(q_count), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int acc_edge;
  logic [31:0] exp_q[$];
  int iss_log[$];
  int ret_log[$];

  // cyc = number of rising edges since reset release (index of the current cycle)
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mov(input logic [2:0] dest, input logic w, input logic [15:0] imm);
    return {1'b1, 6'b0, w, 5'b0, dest, imm};
  endfunction

  function automatic logic [31:0] alu(input logic d, input logic w, input logic [2:0] rg, input logic [2:0] rm);
    return {16'h0, 6'b0, d, w, 2'b0, rg, rm};
  endfunction

  function automatic logic [31:0] perf(input int v);
`ifdef EU_SCHED_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("async_rst_q_count", 32'(q_count), 0);
    chk("async_rst_eu_valid", 32'(eu_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_eu_instr", eu_instr, 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_counters", {cycle_cnt, retire_cnt | stall_cnt}, 0);
    reset = 1'b1;
  endtask

  // ---- driver ----
  task automatic push(input logic [31:0] w);
    bit acc = 1'b0;
    int guard = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (1) begin
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
      guard++;
      if (guard > 50) break;
    end
    if (acc) exp_q.push_back(w);
    else chk("push_timeout", 1, 0);
    @(negedge clk);
    acc_edge = cyc;
    in_valid = 1'b0;
  endtask

  // ---- scoreboard / monitor ----
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      iss_log.delete();
      ret_log.delete();
    end else begin
      if (eu_valid) begin
        iss_log.push_back(cyc);
        if (exp_q.size() == 0) chk("issue_unexpected", eu_instr, 32'hDEAD_0000);
        else chk("eu_instr_order", eu_instr, exp_q.pop_front());
      end
      if (retire) ret_log.push_back(cyc);
    end
  end

  task automatic check_logs(input string tag, input int n, input int first_iss, input int spacing);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_n_issue"}, iss_log.size(), n);
    chk({tag, "_n_retire"}, ret_log.size(), n);
    for (int i = 0; i < n && i < iss_log.size(); i++) begin
      chk({tag, "_issue_cyc"}, iss_log[i], first_iss + spacing * i);
      if (i < ret_log.size()) chk({tag, "_retire_cyc"}, ret_log[i], iss_log[i] + LATENCY - 1);
    end
  endtask

  task automatic check_perf(input string tag, input int stalls, input int retires);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), perf(stalls));
    chk({tag, "_retire_cnt"}, 32'(retire_cnt), perf(retires));
    chk({tag, "_cycle_cnt"}, 32'(cycle_cnt), perf(cyc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int q_tab[9] = '{1, 1, 2, 3, 3, 4, 4, 3, 4};

  initial begin
    #3;
    // reset and release
    do_reset();
    repeat (3) @(negedge clk);
    chk("post_rst_q_count", 32'(q_count), 0);
    chk("post_rst_eu_valid", 32'(eu_valid), 0);
    chk("post_rst_cycle_cnt", 32'(cycle_cnt), perf(3));

    // independent burst: AX then BX back to back
    do_reset();
    push(mov(3'd0, 1'b1, 16'h1234));
    push(mov(3'd1, 1'b1, 16'h1256));
    repeat (4) @(negedge clk);
    check_logs("burst", 2, 2, 1);
    check_perf("burst", 0, 2);

    // RAW: ADD AX,BX waits for MOV BX
    do_reset();
    push(mov(3'd1, 1'b1, 16'h1256));
    push(alu(1'b0, 1'b1, 3'd1, 3'd0));
    repeat (5) @(negedge clk);
    check_logs("raw", 2, 2, LATENCY + 1);
    check_perf("raw", 2, 2);

    // byte aliasing: AL then AH share index bits [1:0]
    do_reset();
    push(mov(3'd0, 1'b0, 16'h0001));
    push(mov(3'd4, 1'b0, 16'h0002));
    repeat (5) @(negedge clk);
    check_logs("alias", 2, 2, LATENCY + 1);
    check_perf("alias", 2, 2);

    // full queue: seven dependent MOV AX words through a 4-deep queue
    do_reset();
    fork
      begin
        for (int i = 0; i < 7; i++) push(mov(3'd0, 1'b1, 16'h1000 + 16'(i)));
      end
      begin
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          chk("full_q_count", 32'(q_count), q_tab[i]);
          chk("full_in_ready", 32'(in_ready), (q_tab[i] < DEPTH) ? 1 : 0);
        end
      end
    join
    chk("full_last_accept_edge", acc_edge, 9);
    repeat (14) @(negedge clk);
    check_logs("full", 7, 2, LATENCY + 1);
    check_perf("full", 12, 7);

    // flush with three queued words, a concurrent push and one instruction in flight
    do_reset();
    push(mov(3'd0, 1'b1, 16'h0001));
    push(mov(3'd0, 1'b1, 16'h0002));
    push(mov(3'd1, 1'b1, 16'h0003));
    push(mov(3'd2, 1'b1, 16'h0004));
    push(mov(3'd3, 1'b1, 16'h0005));
    chk("flush_pre_q_count", 32'(q_count), 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = mov(3'd4, 1'b1, 16'h0006);
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_q_count", 32'(q_count), 0);
    chk("flush_eu_valid", 32'(eu_valid), 0);
    chk("flush_retire_inflight", 32'(retire), 1);
    repeat (5) @(negedge clk);
    check_logs("flush", 2, 2, LATENCY + 1);
    check_perf("flush", 2, 2);

    // reset in mid-operation discards queued words
    push(mov(3'd0, 1'b1, 16'h0007));
    push(mov(3'd0, 1'b1, 16'h0008));
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eu_issue_scheduler.md
# eu_issue_scheduler

Issue scheduler that sits in front of `eu_reg_alu` and drives its 32-bit `instruction_and_imm` input. It buffers decoded instruction words in a small FIFO queue, modelled on the 8086 prefetch queue. It issues at most one word per clock and stalls issue on read-after-write and write-after-write register hazards against instructions still in the EU pipeline. It also reports retirement and, optionally, cycle, retire and stall counts for CPI measurement.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `LATENCY`, 2: EU pipeline depth in cycles, counted from the issue cycle to the writeback cycle; at least 1.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `in_instr`  input  32  instruction word (encoding below).
- `in_valid`  input  1  `in_instr` is valid.
- `in_ready`  output  1  queue can accept a word.
- `flush`  input  1  synchronous queue flush.
- `eu_instr`  output  32  drives `eu_reg_alu.instruction_and_imm`.
- `eu_valid`  output  1  `eu_instr` is newly issued this cycle.
- `retire`  output  1  writeback cycle of an issued instruction.
- `q_count`  output  $clog2(DEPTH)+1  number of queued entries.
- `cycle_cnt`, `retire_cnt`, `stall_cnt`  output  16 each  performance counters.

## Operation
- Encoding of `in_instr`:
  - Bit 31 = 1 selects MOV-immediate. Destination is `[18:16]`, width bit `w` is `[24]`, and there is no source register.
  - Bit 31 = 0 selects ALU reg/reg. `d` is `[9]`, `w` is `[8]`, `reg` is `[5:3]`, `rm` is `[2:0]`.
    - d=0: destination is `rm`, sources are `rm` and `reg`.
    - d=1: destination is `reg`, sources are `reg` and `rm`.
- Register match rule:
  - If both sides have w=1, compare the full 3-bit index.
  - Otherwise compare only index bits `[1:0]`. This is conservative byte/word aliasing.
- Queue behaviour:
  - The queue is a circular FIFO with wrapping read and write pointers.
  - `in_ready` = (`q_count` < DEPTH). It is purely combinational from state, with no same-cycle bypass.
  - A push occurs when `in_valid` and `in_ready` are both high.
- Scoreboard:
  - `sb[0..LATENCY-1]` holds a {valid, dest, w} entry per stage.
  - On every clock the scoreboard shifts by one.
  - `sb[0]` is loaded on issue and cleared otherwise.
- Issue condition: the queue is non-empty and no valid `sb[k]` dest matches any destination or source of the queue head.
- On issue:
  - The head is popped.
  - `eu_instr` is registered with the head word.
  - `eu_valid` = 1 for one cycle.
- When not issuing:
  - `eu_instr` holds its last value.
  - `eu_valid` = 0.
  - The EU gates execution on `eu_valid`.
- Stall counting: a cycle counts as a stall when the queue is non-empty and the issue condition is false.
- `retire` = `sb[LATENCY-1].valid`.
- Simultaneous push and pop are legal; `q_count` is unchanged.
- Flush:
  - `flush` empties the queue at the next edge.
  - A push in the same cycle is dropped.
  - An issue in the same cycle is suppressed.
  - The scoreboard is not cleared, because in-flight instructions still retire.
- Counters wrap at 16'hFFFF to 0.

## Timing
- Reset (async assert) values:
  - Queue empty, pointers 0, `q_count` = 0, `in_ready` = 1.
  - `eu_instr` = 0, `eu_valid` = 0.
  - Scoreboard invalid, `retire` = 0.
  - All counters 0.
- Reset is released synchronously to `clk`.
- Reset in mid-operation discards all queued and in-flight state.
- Push-to-issue latency: a word pushed at edge N into an empty, hazard-free queue gives `eu_valid` = 1 in the cycle after edge N+1.
- Retire timing: an instruction with `eu_valid` in cycle c gives `retire` = 1 in cycle c+LATENCY-1.
- Independent instructions issue back-to-back, one per cycle.
- A dependent instruction issues no earlier than cycle c+LATENCY+1, where c is the producer's `eu_valid` cycle.
- `cycle_cnt` increments every cycle after reset release.

## Configuration
- `EU_SCHED_PERF_CNT_EN`:
  - Defined: `cycle_cnt`, `retire_cnt` and `stall_cnt` are implemented as described.
  - Undefined: no counter flops exist and all three outputs are tied to 16'h0000.
- Issue, hazard and retire behaviour is identical in both configurations.

## Test plan
- Reset: hold `reset` = 0 and then release. Expect `in_ready` = 1, `q_count` = 0, `eu_valid` = 0, `eu_instr` = 32'h0, and all counters 0.
- Independent burst: push MOV AX,0x1234 (`{1,5'b0,0,1,2'b0,1,2'b0,3'b000,16'h1234}`), then MOV BX,0x1256 (dest 001, w=1) on consecutive cycles. Expect `eu_valid` in two consecutive cycles, `stall_cnt` = 0, and two `retire` pulses LATENCY-1 cycles after each issue.
- RAW stall: push MOV BX,0x1256, then ADD AX,BX (`{16'b0,6'b010000,0,1,2'b01,3'b001,3'b000}`). Expect ADD's `eu_valid` exactly LATENCY+1 = 3 cycles after MOV's, and `stall_cnt` = 2.
- Byte aliasing: MOV AL,0x01 (w=0, dest 000), then MOV AH (w=0, dest 100 aliased via bits `[1:0]`). Expect a stall of 2 cycles.
- Full queue: push 5 words with issue blocked by a hazard. Expect `in_ready` = 0 while `q_count` = 4, the 5th word accepted only after the first pop, and FIFO order preserved across pointer wrap.
- Flush: flush with 3 queued words plus a concurrent push. Expect `q_count` = 0 next cycle, no further `eu_valid`, and any in-flight `retire` still asserted on time.
